// File: rtl/i2c_seq_pkg.sv
// Shared types and helpers for the I2C command-table sequencer.
package i2c_seq_pkg;

    // Command opcodes stored in the top two bits of each table entry.
    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_DELAY = 2'd2,
        OP_END   = 2'd3
    } op_t;

    // One table entry: {op, a, b}. For DELAY, {a, b} is the millisecond count.
    typedef struct packed {
        op_t        op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FETCH       = 4'd1,
        ST_DECODE      = 4'd2,
        ST_ISSUE       = 4'd3,
        ST_WAIT_ACCEPT = 4'd4,
        ST_WAIT_DONE   = 4'd5,
        ST_DELAY       = 4'd6,
        ST_NEXT        = 4'd7,
        ST_DONE        = 4'd8
    } state_t;

    // Cycles i_ready may stay high after acceptance before the transaction
    // is taken as already finished.
    localparam logic [1:0] ACCEPT_LAST = 2'd3;

    // Clock cycles per millisecond, never less than one.
    function automatic int ms_ticks(input int clk_freq);
        int t;
        t = clk_freq / 1000;
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/i2c_seq_delay.sv
// Millisecond delay: a 1 ms prescaler feeding a down-counter of milliseconds.
// o_expired is high in the cycle of the final prescaler wrap, so the caller
// can leave its wait state on that same edge.
module i2c_seq_delay
    import i2c_seq_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [15:0] i_ms,
    input  logic        i_run,
    output logic        o_expired
);

    localparam int TICKS = ms_ticks(CLK_FREQ);
    localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS - 1);

    logic [TW-1:0] tick_cnt;
    logic [15:0]   ms_cnt;
    logic          wrap;

    assign wrap      = i_run && (tick_cnt == TICK_MAX);
    assign o_expired = wrap && (ms_cnt == 16'd1);

    // Prescaler counts 0..TICKS-1; each wrap consumes one millisecond.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
        end else if (i_load) begin
            tick_cnt <= '0;
            ms_cnt   <= i_ms;
        end else if (i_run) begin
            if (wrap) begin
                tick_cnt <= '0;
                ms_cnt   <= ms_cnt - 16'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Walks a command table in a synchronous ROM and drives one i2c_master.
// Handshakes: a transfer occurs on a rising i_clk edge where valid and ready
// are both high; valid, once raised, holds with a stable payload until that
// edge; ready may change freely.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int         CLK_FREQ    = 25_000_000,
    parameter int         ROM_AW      = 8,
    parameter logic [6:0] SLAVE_ADDR  = 7'h33,
    parameter int         SCCB_MODE   = 0,
    parameter int         BURST_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [ROM_AW-1:0]      o_rom_addr,
    input  logic [17:0]            i_rom_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_we,
    output logic                   o_sccb_mode,
    output logic [6:0]             o_addr_slave,
    output logic [7:0]             o_addr_reg,
    output logic [BURST_WIDTH-1:0] o_burst_num,
    output logic                   o_wr_fifo_valid,
    output logic [7:0]             o_wr_fifo_data,
    input  logic                   i_wr_fifo_ready,
    input  logic                   i_rd_fifo_valid,
    input  logic [7:0]             i_rd_fifo_data,
    output logic                   o_rd_fifo_ready,
    output logic                   o_rd_valid,
    output logic [7:0]             o_rd_data,
    output logic [7:0]             o_rd_reg,
    output state_t                 o_state
);

    state_t     state;
    cmd_t       cmd;
    logic [1:0] acc_cnt;
    logic       dly_load;
    logic       dly_expired;

    assign cmd          = cmd_t'(i_rom_data);
    assign o_sccb_mode  = (SCCB_MODE != 0);
    assign o_addr_slave = SLAVE_ADDR;
    assign o_burst_num  = '0;
    assign o_state      = state;
    assign dly_load     = (state == ST_DECODE) && (cmd.op == OP_DELAY);

    i2c_seq_delay #(
        .CLK_FREQ (CLK_FREQ)
    ) u_delay (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (dly_load),
        .i_ms      ({cmd.a, cmd.b}),
        .i_run     (state == ST_DELAY),
        .o_expired (dly_expired)
    );

    // Sequencer FSM with all request, write-data and read-capture outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            acc_cnt         <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_rom_addr      <= '0;
            o_valid         <= 1'b0;
            o_we            <= 1'b0;
            o_addr_reg      <= '0;
            o_wr_fifo_valid <= 1'b0;
            o_wr_fifo_data  <= '0;
            o_rd_fifo_ready <= 1'b0;
            o_rd_valid      <= 1'b0;
            o_rd_data       <= '0;
            o_rd_reg        <= '0;
        end else begin
            o_done     <= 1'b0;
            o_rd_valid <= 1'b0;

            // Write data leaves as soon as the master takes it, in any state.
            if (o_wr_fifo_valid && i_wr_fifo_ready)
                o_wr_fifo_valid <= 1'b0;

            // Read byte capture; still taken on the edge where i_ready rises.
            if (i_rd_fifo_valid && o_rd_fifo_ready) begin
                o_rd_data  <= i_rd_fifo_data;
                o_rd_reg   <= o_addr_reg;
                o_rd_valid <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        o_rom_addr <= '0;
                        o_busy     <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    unique case (cmd.op)
                        OP_WRITE: begin
                            o_we            <= 1'b1;
                            o_addr_reg      <= cmd.a;
                            o_wr_fifo_data  <= cmd.b;
                            o_wr_fifo_valid <= 1'b1;
                            o_valid         <= 1'b1;
                            state           <= ST_ISSUE;
                        end
                        OP_READ: begin
                            o_we       <= 1'b0;
                            o_addr_reg <= cmd.a;
                            o_valid    <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                        OP_DELAY: state <= ({cmd.a, cmd.b} == 16'd0) ? ST_NEXT : ST_DELAY;
                        OP_END: begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= ST_DONE;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        acc_cnt <= '0;
                        state   <= ST_WAIT_ACCEPT;
                    end
                end
                ST_WAIT_ACCEPT: begin
                    if (!i_ready) begin
                        o_rd_fifo_ready <= 1'b1;
                        state           <= ST_WAIT_DONE;
                    end else if (acc_cnt == ACCEPT_LAST) begin
                        state <= ST_NEXT;
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_ready) begin
                        o_rd_fifo_ready <= 1'b0;
                        state           <= ST_NEXT;
                    end
                end
                ST_DELAY: begin
                    if (dly_expired)
                        state <= ST_NEXT;
                end
                ST_NEXT: begin
                    o_wr_fifo_valid <= 1'b0;
                    if (o_rom_addr == '1) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        o_rom_addr <= o_rom_addr + 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
